rr_request_arbiter: RTL and testbench
=====================================

// Module: rr_request_arbiter
// PURPOSE
//  Four-requester round-robin arbiter. It sits directly upstream of the 4-to-2 one-hot encoder.
//  It samples four request lines and registers a one-hot grant: grant[0..3] drive encoder
//  inputs z1..z4, and the encoder returns the winner's 2-bit index.
//  The grant is held until the consumer signals done, or until a timeout counter expires.
//  grant_valid qualifies the encoder output, because an all-zero grant also encodes to 00.
// PARAMETERS
//  TIMEOUT  16  max cycles a grant is held without done; legal range 1..2^CNT_W-1
//  CNT_W    5   width of the hold counter
// PORTS
//  clk          in   1  single clock, rising edge
//  rst          in   1  reset, asynchronous, active-high
//  req          in   4  request lines; bit i = requester i; level-sensitive
//  done         in   1  consumer finished with current grant; 1-cycle pulse or level
//  grant        out  4  registered one-hot grant; grant[0..3] -> encoder z1..z4
//  grant_valid  out  1  1 while grant is non-zero
//  timeout      out  1  1-cycle pulse; grant was released by timeout, not by done
// BEHAVIOUR
//  Reset (async, immediate, including mid-grant):
//   - state=IDLE, grant=0, grant_valid=0, timeout=0, cnt=0.
//   - last=3, so requester 0 has highest priority first.
//  Invariant: grant is 0000 or exactly one-hot; grant_valid == |grant at all times.
//  State machine: IDLE, BUSY.
//  IDLE:
//   - If req!=0 at an edge: pick the first set bit scanning (last+1)%4 upward, wrapping 3->0.
//   - Register that one-hot into grant, set grant_valid=1, cnt=0, go to BUSY.
//   - Latency is 1 cycle from the sampled req to grant.
//   - done is ignored in IDLE. req==0 keeps the block in IDLE with grant=0.
//  BUSY:
//   - grant is held stable; changes on req (including the winner dropping its req) are ignored.
//   - done=1 at an edge: grant=0, grant_valid=0, last=winner index, go to IDLE.
//   - else if cnt==TIMEOUT-1: release exactly as for done, and timeout=1 for the following cycle.
//   - else cnt=cnt+1.
//  Hold time: the grant stays up for at most TIMEOUT cycles.
//  done on the same edge as cnt==TIMEOUT-1: done wins and no timeout pulse is issued.
//  Every release is followed by at least one IDLE cycle with grant=0 before the next grant.
//   This gives the encoder a clean gap between consecutive winners.
//  timeout otherwise 0; it is a registered output, high only for the one cycle after a timeout release.
//  Pointer wrap: after winner 3, the scan starts at 0. Non-requesting bits are skipped.
// TESTING
//  1. rst, then req=0001 -> next cycle grant=0001, grant_valid=1; done pulse -> next cycle grant=0000, valid=0.
//  2. req=1111 held, done pulsed each grant -> grants 0001,0010,0100,1000,0001, each separated by one 0000 cycle.
//  3. Win with requester 2 (last=2), then req=0011 -> grant=0001 (scan 3, wrap to 0); next grant=0010.
//  4. TIMEOUT=16, grant taken, done never asserted -> grant held 16 cycles, then 0000 with timeout=1 for exactly 1 cycle.
//  5. done asserted on the same edge as cnt==TIMEOUT-1 -> grant released, timeout stays 0.
//  6. rst asserted between edges mid-BUSY -> grant/valid drop immediately; after release, req=1001 -> grant=0001.

Source files
------------

// File: rtl/rr_request_arbiter.sv
// rr_request_arbiter
//   Four-requester round-robin arbiter feeding a 4-to-2 one-hot encoder.
//   A registered one-hot grant is held until done, or until TIMEOUT cycles
//   have elapsed, after which a one-cycle timeout pulse is issued.
//   Every release is followed by at least one idle cycle with grant=0.
// Ports
//   clk          in   1  rising-edge clock
//   rst          in   1  asynchronous active-high reset
//   req          in   4  level-sensitive request lines, bit i = requester i
//   done         in   1  consumer finished with current grant
//   grant        out  4  registered one-hot grant (grant[0..3] -> z1..z4)
//   grant_valid  out  1  high while grant is non-zero
//   timeout      out  1  one-cycle pulse after a timeout release
module rr_request_arbiter #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] grant,
   output logic       grant_valid,
   output logic       timeout
);

   localparam int unsigned N_REQ = 4;
   localparam int unsigned IDX_W = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [IDX_W-1:0]   win_q, win_d;
   logic [N_REQ-1:0]   grant_d;
   logic               grant_valid_d;
   logic               timeout_d;

   logic [IDX_W-1:0]   pick_idx;
   logic               pick_found;
   logic               hold_expired;

   // Round-robin scan starting one past the last winner, wrapping 3->0.
   always_comb begin
      logic [IDX_W-1:0] idx;
      pick_idx   = '0;
      pick_found = 1'b0;
      idx        = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         idx = IDX_W'(last_q + IDX_W'(i));
         if (!pick_found && req[idx]) begin
            pick_idx   = idx;
            pick_found = 1'b1;
         end
      end
   end

   assign hold_expired = (cnt_q == CNT_W'(TIMEOUT - 1));

   // Next-state and next-output logic.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      last_d        = last_q;
      win_d         = win_q;
      grant_d       = grant;
      grant_valid_d = grant_valid;
      timeout_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            grant_d       = '0;
            grant_valid_d = 1'b0;
            if (pick_found) begin
               grant_d       = N_REQ'(1) << pick_idx;
               grant_valid_d = 1'b1;
               win_d         = pick_idx;
               cnt_d         = '0;
               state_d       = BUSY;
            end
         end
         BUSY: begin
            // done takes priority over an expiring hold counter
            if (done || hold_expired) begin
               grant_d       = '0;
               grant_valid_d = 1'b0;
               last_d        = win_q;
               cnt_d         = '0;
               timeout_d     = !done;
               state_d       = IDLE;
            end else begin
               cnt_d = CNT_W'(cnt_q + CNT_W'(1));
            end
         end
         default: begin
            state_d       = IDLE;
            grant_d       = '0;
            grant_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         last_q      <= IDX_W'(N_REQ - 1);
         win_q       <= '0;
         grant       <= '0;
         grant_valid <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         win_q       <= win_d;
         grant       <= grant_d;
         grant_valid <= grant_valid_d;
         timeout     <= timeout_d;
      end
   end

endmodule

// File: tb/tb_rr_request_arbiter.sv
// tb_rr_request_arbiter
//   Directed-vector bench for rr_request_arbiter (TIMEOUT=16, CNT_W=5).
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rr_request_arbiter;

   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned CNT_W   = 5;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       done;
   logic [3:0] grant;
   logic       grant_valid;
   logic       timeout;

   int n_tests;
   int n_fail;

   rr_request_arbiter #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #100000;
      $display("FAIL watchdog: got=sim_time_expired exp=sequence_complete");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [3:0] g, input logic v, input logic t);
      check({tag, ".grant"}, 32'(grant), 32'(g));
      check({tag, ".valid"}, 32'(grant_valid), 32'(v));
      check({tag, ".timeout"}, 32'(timeout), 32'(t));
   endtask

   initial begin
      logic [3:0] exp_seq [5];
      n_tests = 0;
      n_fail  = 0;
      rst  = 1'b1;
      req  = 4'b0000;
      done = 1'b0;
      tick();
      tick();
      check_out("reset", 4'b0000, 1'b0, 1'b0);
      rst = 1'b0;

      // 1: single request, done release
      req = 4'b0001;
      tick();
      check_out("t1_grant", 4'b0001, 1'b1, 1'b0);
      req  = 4'b0000;
      done = 1'b1;
      tick();
      check_out("t1_release", 4'b0000, 1'b0, 1'b0);
      done = 1'b0;
      tick();
      check_out("t1_idle", 4'b0000, 1'b0, 1'b0);

      // 2: all requesting, rotation from a fresh reset
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      exp_seq[0] = 4'b0001;
      exp_seq[1] = 4'b0010;
      exp_seq[2] = 4'b0100;
      exp_seq[3] = 4'b1000;
      exp_seq[4] = 4'b0001;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         check_out($sformatf("t2_grant%0d", k), exp_seq[k], 1'b1, 1'b0);
         done = 1'b1;
         tick();
         check_out($sformatf("t2_gap%0d", k), 4'b0000, 1'b0, 1'b0);
         done = 1'b0;
      end

      // 3: win with requester 2, then wrap past 3 to 0, then 1
      req = 4'b0100;
      tick();
      check_out("t3_win2", 4'b0100, 1'b1, 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;
      req  = 4'b0011;
      tick();
      check_out("t3_wrap0", 4'b0001, 1'b1, 1'b0);
      done = 1'b1;
      tick();
      check_out("t3_gap", 4'b0000, 1'b0, 1'b0);
      done = 1'b0;
      tick();
      check_out("t3_next1", 4'b0010, 1'b1, 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;
      req  = 4'b0000;

      // 4: timeout release, grant held 16 cycles despite req dropping
      req = 4'b0001;
      tick();
      check_out("t4_grant", 4'b0001, 1'b1, 1'b0);
      req = 4'b0000;
      for (int k = 1; k < 16; k++) begin
         tick();
         check_out($sformatf("t4_hold%0d", k), 4'b0001, 1'b1, 1'b0);
      end
      tick();
      check_out("t4_expire", 4'b0000, 1'b0, 1'b1);
      tick();
      check_out("t4_pulse_end", 4'b0000, 1'b0, 1'b0);

      // 5: done coincides with the final hold cycle, no timeout pulse
      req = 4'b0010;
      tick();
      check_out("t5_grant", 4'b0010, 1'b1, 1'b0);
      for (int k = 1; k < 16; k++) tick();
      check_out("t5_last_hold", 4'b0010, 1'b1, 1'b0);
      done = 1'b1;
      tick();
      check_out("t5_release", 4'b0000, 1'b0, 1'b0);
      done = 1'b0;
      req  = 4'b0000;
      tick();
      check_out("t5_after", 4'b0000, 1'b0, 1'b0);

      // 6: asynchronous reset mid-grant, then pointer back at requester 0
      req = 4'b0100;
      tick();
      check_out("t6_grant", 4'b0100, 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("t6_async.grant", 32'(grant), 32'h0);
      check("t6_async.valid", 32'(grant_valid), 32'h0);
      #1 rst = 1'b0;
      req = 4'b1001;
      tick();
      check_out("t6_after_rst", 4'b0001, 1'b1, 1'b0);
      req = 4'b1000;
      tick();
      check_out("t6_held", 4'b0001, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
